vram_access_scheduler: RTL and testbench

- Time-shares one single-port synchronous video RAM between two users:
  - the CRT pixel fetch path, driven by the CRT controller's PixelClock enable and xpos/ypos;
  - the game-logic read/write port.
- Display fetches have absolute priority. Game accesses fill the idle system-clock slots between pixel ticks.
- Sits between the CRT controller, the pong game FSM and the VRAM block.

---
 rtl/vram_access_scheduler.sv | 129 ++++++++++++
 tb/tb_vram_access_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_scheduler.sv
// Shares one single-port synchronous VRAM between CRT pixel fetches (priority) and game accesses.
// Optional: define VRAM_BLANK_ONLY_WRITES_EN to admit game writes only during blanking.
module vram_access_scheduler #(
    parameter int ResolutionSize = 10,
    parameter int AddrSize       = 12,
    parameter int DataSize       = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      PixelClock,
    input  logic [ResolutionSize-1:0] xpos,
    input  logic [ResolutionSize-1:0] ypos,
    input  logic [ResolutionSize-1:0] Xresolution,
    input  logic [ResolutionSize-1:0] Yresolution,
    input  logic                      GameReq,
    input  logic                      GameWe,
    input  logic [AddrSize-1:0]       GameAddr,
    input  logic [DataSize-1:0]       GameWData,
    output logic                      GameAck,
    output logic [DataSize-1:0]       GameRData,
    output logic [AddrSize-1:0]       MemAddr,
    output logic                      MemWe,
    output logic [DataSize-1:0]       MemWData,
    input  logic [DataSize-1:0]       MemRData,
    output logic [DataSize-1:0]       PixelData,
    output logic                      PixelValid,
    output logic                      Underrun
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DISP      = 3'd1,
        DISP_DATA = 3'd2,
        GAME      = 3'd3,
        GAME_DATA = 3'd4
    } state_t;

    state_t              state;
    logic [AddrSize-1:0] disp_addr;
    logic                disp_pending;
    logic                game_we_q;

    logic active;
    logic pix_act;
    logic pix_blank;
    logic disp_need;
    logic game_go;

    assign active    = (xpos < Xresolution) && (ypos < Yresolution);
    assign pix_act   = PixelClock && active;
    assign pix_blank = PixelClock && !active;
    assign disp_need = disp_pending || pix_act;

`ifdef VRAM_BLANK_ONLY_WRITES_EN
    // Writes wait for blanking so the visible frame is never torn; reads go anywhere.
    assign game_go = GameReq && !(GameWe && active);
`else
    assign game_go = GameReq;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            disp_addr    <= '0;
            disp_pending <= 1'b0;
            game_we_q    <= 1'b0;
            GameAck      <= 1'b0;
            GameRData    <= '0;
            MemAddr      <= '0;
            MemWe        <= 1'b0;
            MemWData     <= '0;
            PixelData    <= '0;
            PixelValid   <= 1'b0;
            Underrun     <= 1'b0;
        end else begin
            MemWe      <= 1'b0;
            GameAck    <= 1'b0;
            PixelValid <= 1'b0;

            // Memory-side outputs are loaded on entry so they are visible during DISP/GAME.
            case (state)
                IDLE: begin
                    if (disp_need) begin
                        state     <= DISP;
                        MemAddr   <= disp_addr;
                        disp_addr <= disp_addr + AddrSize'(1);
                    end else if (game_go) begin
                        state     <= GAME;
                        MemAddr   <= GameAddr;
                        MemWe     <= GameWe;
                        MemWData  <= GameWData;
                        game_we_q <= GameWe;
                    end
                end
                DISP:      state <= DISP_DATA;
                DISP_DATA: begin
                    state      <= IDLE;
                    PixelData  <= MemRData;
                    PixelValid <= 1'b1;
                end
                GAME:      state <= GAME_DATA;
                GAME_DATA: begin
                    state   <= IDLE;
                    GameAck <= 1'b1;
                    if (!game_we_q)
                        GameRData <= MemRData;
                end
                default:   state <= IDLE;
            endcase

            // A pending fetch is consumed in DISP; a second tick before that is lost.
            if (pix_act) begin
                disp_pending <= 1'b1;
                if (disp_pending && (state != DISP))
                    Underrun <= 1'b1;
            end else if (state == DISP) begin
                disp_pending <= 1'b0;
            end

            if (pix_blank) begin
                PixelData  <= '0;
                PixelValid <= 1'b0;
                if (ypos >= Yresolution)
                    disp_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a behavioural synchronous VRAM.
module tb_vram_access_scheduler;

    localparam int RS = 10;
    localparam int AS = 12;
    localparam int DS = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          PixelClock;
    logic [RS-1:0] xpos, ypos, Xresolution, Yresolution;
    logic          GameReq, GameWe;
    logic [AS-1:0] GameAddr;
    logic [DS-1:0] GameWData;
    logic          GameAck;
    logic [DS-1:0] GameRData;
    logic [AS-1:0] MemAddr;
    logic          MemWe;
    logic [DS-1:0] MemWData;
    logic [DS-1:0] MemRData;
    logic [DS-1:0] PixelData;
    logic          PixelValid;
    logic          Underrun;

    int errors = 0;
    int checks = 0;

    logic [DS-1:0] mem [0:(1<<AS)-1];

    vram_access_scheduler #(.ResolutionSize(RS), .AddrSize(AS), .DataSize(DS)) dut (
        .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
        .xpos(xpos), .ypos(ypos), .Xresolution(Xresolution), .Yresolution(Yresolution),
        .GameReq(GameReq), .GameWe(GameWe), .GameAddr(GameAddr), .GameWData(GameWData),
        .GameAck(GameAck), .GameRData(GameRData),
        .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData),
        .PixelData(PixelData), .PixelValid(PixelValid), .Underrun(Underrun)
    );

    always #5 Clock = ~Clock;

    // Read-first synchronous RAM: data appears one cycle after the address.
    always @(posedge Clock) begin
        if (MemWe) mem[MemAddr] <= MemWData;
        MemRData <= mem[MemAddr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; PixelClock = 1'b0; xpos = '0; ypos = '0;
        Xresolution = 10'd8; Yresolution = 10'd4;
        GameReq = 1'b0; GameWe = 1'b0; GameAddr = '0; GameWData = '0;
        step(2);
        checks++; if (GameAck !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", GameAck); end
        checks++; if (GameRData !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", GameRData); end
        checks++; if (MemAddr !== 12'h000) begin errors++; $display("FAIL reset_memaddr got %h want 000", MemAddr); end
        checks++; if (MemWe !== 1'b0 || MemWData !== 8'h00) begin errors++; $display("FAIL reset_memwr got we=%b d=%h want 0/00", MemWe, MemWData); end
        checks++; if (PixelData !== 8'h00 || PixelValid !== 1'b0) begin errors++; $display("FAIL reset_pixel got %h/%b want 00/0", PixelData, PixelValid); end
        checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", Underrun); end
        Reset = 1'b0;
        step(2);
    endtask

    task automatic test_frame;
        int  expv;
        bit  act;
        expv = 0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 10; x++) begin
                xpos = RS'(x); ypos = RS'(y); PixelClock = 1'b1;
                act = (x < 8) && (y < 4);
                step(1);
                PixelClock = 1'b0;
                if (act) begin
                    checks++;
                    if (MemAddr !== 12'(expv)) begin errors++; $display("FAIL frame_addr x=%0d y=%0d got %h want %h", x, y, MemAddr, 12'(expv)); end
                end
                step(2);
                checks++;
                if (act) begin
                    if (PixelValid !== 1'b1 || PixelData !== expv[7:0]) begin errors++; $display("FAIL frame_pix x=%0d y=%0d got %h/%b want %h/1", x, y, PixelData, PixelValid, expv[7:0]); end
                    expv++;
                end else begin
                    if (PixelValid !== 1'b0 || PixelData !== 8'h00) begin errors++; $display("FAIL frame_blank x=%0d y=%0d got %h/%b want 00/0", x, y, PixelData, PixelValid); end
                end
                step(3);
            end
        end
        checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL frame_underrun got %b want 0", Underrun); end
        // New frame must restart at address 0.
        xpos = '0; ypos = '0; PixelClock = 1'b1;
        step(1);
        PixelClock = 1'b0;
        checks++; if (MemAddr !== 12'h000) begin errors++; $display("FAIL frame_restart_addr got %h want 000", MemAddr); end
        step(2);
        checks++; if (PixelValid !== 1'b1 || PixelData !== 8'h00) begin errors++; $display("FAIL frame_restart_pix got %h/%b want 00/1", PixelData, PixelValid); end
        step(3);
    endtask

    task automatic test_priority;
        xpos = '0; ypos = '0;
        PixelClock = 1'b1; GameReq = 1'b1; GameWe = 1'b0; GameAddr = 12'h100;
        step(1);
        PixelClock = 1'b0;
        checks++; if (MemAddr !== 12'h001 || MemWe !== 1'b0) begin errors++; $display("FAIL prio_disp_first got %h/%b want 001/0", MemAddr, MemWe); end
        step(2);
        checks++; if (PixelValid !== 1'b1 || PixelData !== 8'h01) begin errors++; $display("FAIL prio_pixel got %h/%b want 01/1", PixelData, PixelValid); end
        step(1);
        checks++; if (MemAddr !== 12'h100) begin errors++; $display("FAIL prio_game_addr got %h want 100", MemAddr); end
        step(1);
        checks++; if (GameAck !== 1'b0) begin errors++; $display("FAIL prio_early_ack got %b want 0", GameAck); end
        step(1);
        checks++; if (GameAck !== 1'b1 || GameRData !== 8'h01) begin errors++; $display("FAIL prio_ack got %b/%h want 1/01", GameAck, GameRData); end
        GameReq = 1'b0;
        step(1);
        checks++; if (GameAck !== 1'b0) begin errors++; $display("FAIL prio_ack_pulse got %b want 0", GameAck); end
    endtask

    task automatic test_write_read;
        int we_cnt, ack_cnt;
        we_cnt = 0; ack_cnt = 0;
        xpos = 10'd8; ypos = '0;
        GameReq = 1'b1; GameWe = 1'b1; GameAddr = 12'h020; GameWData = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            if (MemWe === 1'b1) we_cnt++;
            if (GameAck === 1'b1) ack_cnt++;
            if (c == 1) begin
                checks++; if (MemWe !== 1'b1 || MemAddr !== 12'h020 || MemWData !== 8'hA5) begin errors++; $display("FAIL wr_issue got we=%b a=%h d=%h want 1/020/a5", MemWe, MemAddr, MemWData); end
            end
            if (c == 3) begin
                checks++; if (GameAck !== 1'b1 || GameRData !== 8'h01) begin errors++; $display("FAIL wr_ack got %b/%h want 1/01", GameAck, GameRData); end
                GameWe = 1'b0;
            end
            if (c == 6) begin
                checks++; if (GameAck !== 1'b1 || GameRData !== 8'hA5) begin errors++; $display("FAIL rd_back got %b/%h want 1/a5", GameAck, GameRData); end
                GameReq = 1'b0;
            end
        end
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL wr_we_cycles got %0d want 1", we_cnt); end
        checks++; if (ack_cnt != 2) begin errors++; $display("FAIL wr_ack_count got %0d want 2", ack_cnt); end
    endtask

    task automatic test_underrun;
        bit found;
        int ack_cnt;
        xpos = '0; ypos = '0;
        checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_pre got %b want 0", Underrun); end
        GameReq = 1'b1; GameWe = 1'b0; GameAddr = 12'h005;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            PixelClock = k[0];
        end
        step(1);
        PixelClock = 1'b0;
        checks++; if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_set got %b want 1", Underrun); end
        GameReq = 1'b0;
        step(6);
        checks++; if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b want 1", Underrun); end
        xpos = 10'd8;
        GameReq = 1'b1; GameWe = 1'b1; GameAddr = 12'h030; GameWData = 8'h5A;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(1);
            if (MemWe === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL ur_wait_we got 0 want 1"); end
        Reset = 1'b1; GameReq = 1'b0;
        #1;
        checks++; if (MemWe !== 1'b0) begin errors++; $display("FAIL ur_async_we got %b want 0", MemWe); end
        checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_cleared got %b want 0", Underrun); end
        step(1);
        Reset = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (GameAck === 1'b1) ack_cnt++;
        end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL ur_abort_ack got %0d want 0", ack_cnt); end
    endtask

    task automatic test_write_gate;
        int early;
        xpos = 10'd3; ypos = 10'd1;
        GameReq = 1'b1; GameWe = 1'b1; GameAddr = 12'h040; GameWData = 8'h3C;
`ifdef VRAM_BLANK_ONLY_WRITES_EN
        early = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (GameAck === 1'b1 || MemWe === 1'b1) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL gate_blocked got %0d want 0", early); end
        xpos = 10'd8;
`endif
        for (int c = 1; c <= 3; c++) begin
            step(1);
            checks++;
            if (GameAck !== (c == 3)) begin errors++; $display("FAIL gate_wr_ack c=%0d got %b want %b", c, GameAck, c == 3); end
        end
        GameReq = 1'b0;
        step(1);
        xpos = 10'd3;
        GameReq = 1'b1; GameWe = 1'b0;
        step(3);
        checks++; if (GameAck !== 1'b1 || GameRData !== 8'h3C) begin errors++; $display("FAIL gate_rd got %b/%h want 1/3c", GameAck, GameRData); end
        GameReq = 1'b0;
        step(1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AS); i++) mem[i] = 8'(i) ^ {4'h0, 4'(i >> 8)};
        test_reset();
        test_frame();
        test_priority();
        test_write_read();
        test_underrun();
        test_write_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
